// File: rtl/pwl_pkg.sv
// Shared formats, chord-fit coefficient tables and the round/saturate helper
// for the tanh piecewise-linear approximator.
package pwl_pkg;

    localparam int M         = 4;
    localparam int N         = 8;
    localparam int WIDTH     = M + N;
    localparam int U         = 8;
    localparam int V         = 4;
    localparam int K_WIDTH_I = 4;
    localparam int K_WIDTH_F = 12;
    localparam int B_WIDTH_I = 4;
    localparam int B_WIDTH_F = 12;
    localparam int K_WIDTH   = K_WIDTH_I + K_WIDTH_F;
    localparam int B_WIDTH   = B_WIDTH_I + B_WIDTH_F;
    localparam int IDX_W     = $clog2(U);
    localparam int IDX_SHIFT = N + V - 1 - IDX_W;
    localparam int B_SHIFT   = N + K_WIDTH_F - B_WIDTH_F;
    localparam int ACC_W     = WIDTH + K_WIDTH + 2;

    typedef logic signed [K_WIDTH-1:0] k_t;
    typedef logic signed [B_WIDTH-1:0] b_t;

    // Chord fits of tanh between integer points, Q4.12, round-to-nearest.
    // Regenerate with the same rule whenever U, V or N change.
    localparam k_t K_TABLE [U] = '{
        16'sd3119, 16'sd829, 16'sd127, 16'sd18,
        16'sd2,    16'sd0,   16'sd0,   16'sd0
    };
    localparam b_t B_TABLE [U] = '{
        16'sd0,    16'sd2290, 16'sd3694, 16'sd4023,
        16'sd4084, 16'sd4094, 16'sd4096, 16'sd4096
    };

    localparam logic signed [ACC_W-1:0] RND_HALF =
        {{(ACC_W-K_WIDTH_F){1'b0}}, 1'b1, {(K_WIDTH_F-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

    // Round half up, clamp the magnitude to [0, 2^(WIDTH-1)-1], restore sign.
    function automatic logic signed [WIDTH-1:0] round_sat(
        input logic signed [ACC_W-1:0] acc,
        input logic                    sgn
    );
        logic signed [ACC_W-1:0] r;
        logic        [WIDTH-2:0] mag;
        r = (acc + RND_HALF) >>> K_WIDTH_F;
        if (r < $signed({ACC_W{1'b0}})) begin
            mag = {(WIDTH-1){1'b0}};
        end else if (r > Y_MAX) begin
            mag = {(WIDTH-1){1'b1}};
        end else begin
            mag = (WIDTH-1)'(r);
        end
        return sgn ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

endpackage

// File: rtl/pwl_coeff_rom.sv
// Combinational segment index to {slope, intercept} lookup.
module pwl_coeff_rom
    import pwl_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output k_t               k,
    output b_t               b
);

    // Table read; every index of IDX_W bits maps to a populated entry.
    always_comb begin
        k = K_TABLE[idx];
        b = B_TABLE[idx];
    end

endmodule

// File: rtl/pwl.sv
// Two-stage pipelined tanh approximator: y = sign(x) * (k_i*|x| + b_i).
module pwl
    import pwl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] x_in,
    output logic signed [WIDTH-1:0] y_out
);

    localparam logic signed [WIDTH-1:0] X_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic                    s_s;
    logic [WIDTH-2:0]        a_s;
    logic [IDX_W-1:0]        idx_s;
    k_t                      k_s;
    b_t                      b_s;

    logic                    s_r;
    logic [WIDTH-2:0]        a_r;
    k_t                      k_r;
    b_t                      b_r;

    logic signed [ACC_W-1:0] p_s;
    logic signed [ACC_W-1:0] acc_s;

    // Sign/magnitude split; the most negative code has no positive twin,
    // so it is clamped to the largest magnitude.
    always_comb begin
        s_s = x_in[WIDTH-1];
        if (x_in == X_MIN) begin
            a_s = {(WIDTH-1){1'b1}};
        end else if (s_s) begin
            a_s = (WIDTH-1)'(-x_in);
        end else begin
            a_s = (WIDTH-1)'(x_in);
        end
        idx_s = IDX_W'(a_s >> IDX_SHIFT);
    end

    pwl_coeff_rom u_rom (
        .idx (idx_s),
        .k   (k_s),
        .b   (b_s)
    );

    // Stage 1: capture sign, magnitude and the selected segment coefficients.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r <= 1'b0;
            a_r <= {(WIDTH-1){1'b0}};
            k_r <= {K_WIDTH{1'b0}};
            b_r <= {B_WIDTH{1'b0}};
        end else begin
            s_r <= s_s;
            a_r <= a_s;
            k_r <= k_s;
            b_r <= b_s;
        end
    end

    // Full-precision MAC; the intercept is aligned to the product's binary point.
    always_comb begin
        p_s   = ACC_W'(k_r) * ACC_W'($signed({1'b0, a_r}));
        acc_s = p_s + (ACC_W'(b_r) <<< B_SHIFT);
    end

    // Stage 2: round, saturate and re-apply the sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_out <= {WIDTH{1'b0}};
        end else begin
            y_out <= round_sat(acc_s, s_r);
        end
    end

endmodule

// File: tb/tb_pwl.sv
// Self-checking bench for pwl: directed steps, reset cases, random stimulus
// and a full code sweep against an arithmetic reference of the PWL rule.
module tb_pwl;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [11:0] x_in;
    logic signed [11:0] y_out;

    int total = 0;
    int bad   = 0;

    int kt [8] = '{3119, 829, 127, 18, 2, 0, 0, 0};
    int bt [8] = '{0, 2290, 3694, 4023, 4084, 4094, 4096, 4096};

    // inputs driven one and two steps ago
    int x1 = 0, x2 = 0;
    bit r1 = 1'b1, r2 = 1'b1;

    bit                 mono_on = 1'b0;
    bit                 mono_valid = 1'b0;
    logic signed [11:0] prev_y;

    pwl dut (
        .clk   (clk),
        .rst   (rst),
        .x_in  (x_in),
        .y_out (y_out)
    );

    always #5 clk = ~clk;

    function automatic int model(input int x);
        int a, i, r;
        a = (x < 0) ? -x : x;
        if (a > 2047) a = 2047;
        i = a / 256;
        r = (kt[i] * a + bt[i] * 256 + 2048) / 4096;
        if (r > 2047) r = 2047;
        if (r < 0) r = 0;
        return (x < 0) ? -r : r;
    endfunction

    // check the output for the input driven two steps ago, then drive new input
    task automatic step(input int x, input bit r, input string tag);
        int                 e;
        logic signed [11:0] ev;
        @(negedge clk);
        e  = (r1 || r2) ? 0 : model(x2);
        ev = 12'(e);
        total++;
        assert (y_out === ev) else begin
            bad++;
            $error("FAIL %s: x=%0d y_out=%0d expected=%0d", tag, x2, y_out, ev);
        end
        if (mono_on && !r1 && !r2 && x2 > 0) begin
            if (mono_valid) begin
                total++;
                assert (y_out >= prev_y) else begin
                    bad++;
                    $error("FAIL monotonic: x=%0d y_out=%0d previous=%0d", x2, y_out, prev_y);
                end
            end
            prev_y     = y_out;
            mono_valid = 1'b1;
        end
        x2   = x1;
        r2   = r1;
        x1   = x;
        r1   = r;
        x_in = 12'(x);
        rst  = r;
    endtask

    initial begin
        rst  = 1'b1;
        x_in = 12'sd1024;

        // reset held with a non-zero input, then two zero cycles after release
        for (int i = 0; i < 3; i++) step(1024, 1'b1, "reset");

        // directed positives, then symmetry and the clamp path
        step(0,     1'b0, "dir_zero");
        step(1024,  1'b0, "dir_4p0");
        step(2047,  1'b0, "dir_max");
        step(15,    1'b0, "dir_15");
        step(1,     1'b0, "dir_1");
        step(512,   1'b0, "dir_2p0");
        step(-1024, 1'b0, "sym_m4p0");
        step(-15,   1'b0, "sym_m15");
        step(-2048, 1'b0, "sym_clamp");

        // back-to-back sequence with a one-cycle reset pulse inside it
        step(0,    1'b0, "b2b");
        step(1024, 1'b0, "b2b");
        step(2047, 1'b0, "b2b");
        step(15,   1'b0, "b2b");
        step(1,    1'b0, "b2b");
        step(0,    1'b0, "b2b");
        step(1024, 1'b1, "midrst");
        step(2047, 1'b0, "midrst");
        step(15,   1'b0, "midrst");
        step(1,    1'b0, "midrst");
        step(-512, 1'b0, "midrst");

        // random codes with occasional reset pulses
        for (int i = 0; i < 600; i++) begin
            step(int'($urandom_range(4095)) - 2048, ($urandom_range(31) == 0), "random");
        end
        step(0, 1'b0, "random");

        // exhaustive sweep; monotonicity tracked over the positive range
        mono_on = 1'b1;
        for (int x = -2048; x < 2048; x++) step(x, 1'b0, "sweep");
        step(0, 1'b0, "sweep");
        step(0, 1'b0, "sweep");
        mono_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwl.md
# pwl

Piecewise-linear (PWL) approximator of the odd-symmetric activation tanh(x) for the activation datapath. It exploits symmetry: it evaluates y = k·|x| + b on |x| using a U-entry slope/intercept table, then restores the input sign. It is fully pipelined, accepting one sample per clock with a fixed 2-cycle latency.

## Interface
- M, 4, integer bits of x/y including sign; WIDTH = M+N
- N, 8, fractional bits of x/y (Q4.8 by default)
- U, 8, number of uniform segments over |x| ∈ [0, 2^(V-1))
- V, 4, segmented range exponent; segment width = 2^(V-1)/U (1.0 by default)
- K_WIDTH_I, 4, slope integer bits including sign
- K_WIDTH_F, 12, slope fractional bits
- B_WIDTH_I, 4, intercept integer bits including sign
- B_WIDTH_F, 12, intercept fractional bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- x_in  input  WIDTH, signed  sample in QM.N
- y_out  output  WIDTH, signed  registered tanh approximation in QM.N

## Operation
- Sign/magnitude:
  - s = x_in[WIDTH-1].
  - a = |x_in|.
  - The most negative code (-2048) is clamped to a = 2^(WIDTH-1)-1.
- Segment index: i = a >> (N + V - 1 - log2 U), i.e. a[10:8] by default.
  - i is always within 0..U-1.
- Table entries, k_i in Q4.12 and b_i in Q4.12, are chord fits of tanh between integer points, rounded to nearest:
  - k = {3119, 829, 127, 18, 2, 0, 0, 0}.
  - b = {0, 2290, 3694, 4023, 4084, 4094, 4096, 4096}.
- MAC:
  - p = k_i·a, full precision (Q.N+K_WIDTH_F).
  - acc = p + (b_i << (N + K_WIDTH_F − B_WIDTH_F)), with at least WIDTH+K_WIDTH+2 bits.
- Rounding: r = (acc + 2^(K_WIDTH_F−1)) >> K_WIDTH_F, i.e. round half up.
- Saturation: clamp r to [0, 2^(WIDTH-1)-1].
- Output: y = s ? −r : r.
- Result properties:
  - Output is exactly odd-symmetric: y(−x) = −y(x).
  - x = 0 gives y = 0.

## Timing
- Stage 1, on the edge after x_in is sampled: register s, a, k_i, b_i.
- Stage 2: register the MAC, rounding, saturation and sign result into y_out.
- Latency and throughput:
  - Latency is 2 cycles: x_in sampled at edge n appears on y_out after edge n+2.
  - Throughput is 1 sample/cycle; x_in may change every cycle.
- Reset:
  - While rst = 1 at an edge, all pipeline registers and y_out clear to 0.
  - The first valid output appears 2 edges after rst deasserts.
  - Reset asserted mid-stream discards all in-flight samples.
- There is no handshake and no valid signal; the block is free-running.

## Structure
- Shared package pwl_pkg holds:
  - the default Q formats;
  - the k/b coefficient arrays, `localparam` of U entries;
  - a saturate/round function.
- Changing U, V or N requires regenerating the table with the same chord-fit rule.
- Sub-module pwl_coeff_rom: combinational index → {k, b} lookup.
- Top-level pwl holds the abs/sign logic, both pipeline stages and the MAC.

## Test plan
- Reset: assert rst with x_in = 1024 -> y_out = 0 throughout reset and for 2 cycles after it releases.
- Directed positives, one per cycle, each checked 2 cycles later:
  - x_in = 0 -> 0
  - x_in = 1024 (4.0) -> 256
  - x_in = 2047 -> 256
  - x_in = 15 -> 11
  - x_in = 1 -> 1
  - x_in = 512 (2.0) -> 247
- Symmetry/boundary:
  - x_in = −1024 -> −256
  - x_in = −15 -> −11
  - x_in = −2048 -> −256 (clamp path)
- Back-to-back: change x_in every cycle through 0, 1024, 2047, 15, 1 -> outputs match in the same order, each with exactly 2-cycle latency.
- Mid-stream reset: pulse rst for one cycle during the sequence -> y_out = 0 for the following 2 cycles, then resumes with the correct values.
- Sweep: all 4096 codes against the golden model -> exact match, including monotonic non-decreasing output over the positive range.
